// File: rtl/pdec_dp2sp_nbank_if.sv
// Logical dual-port RAM bus: one write port with ready, one read port with a
// fixed-latency valid/data return.
interface pdec_dp2sp_nbank_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wready;
  logic          ren;
  logic [AW-1:0] raddr;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output wen, waddr, wdata, ren, raddr, input wready, rvalid, rdata);
  modport slave  (input wen, waddr, wdata, ren, raddr, output wready, rvalid, rdata);
endinterface

// File: rtl/pdec_dp2sp_nbank.sv
// Dual-port RAM emulated on 2^BW address-interleaved single-port banks; the read
// always wins a bank conflict and the losing write waits in an in-order buffer.
module pdec_dp2sp_nbank #(
  parameter int DW       = 16,
  parameter int AW       = 8,
  parameter int BW       = 1,
  parameter int SRAM_DLY = 2,
  parameter int WB_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  pdec_dp2sp_nbank_if.slave             dpram,
  output logic [3:0]                    wbuf_level,
  output logic                          wr_ovf,
  output logic [(1<<BW)-1:0]            spram_ce,
  output logic [(1<<BW)-1:0]            spram_we,
  output logic [(1<<BW)*(AW-BW)-1:0]    spram_addr,
  output logic [(1<<BW)*DW-1:0]         spram_wdata,
  input  logic [(1<<BW)*DW-1:0]         spram_rdata
);
  localparam int BANKS = 1 << BW;
  localparam int RW    = AW - BW;

  logic [3:0]    level_q, level_d, tail;
  logic [AW-1:0] wb_addr_q [WB_DEPTH];
  logic [AW-1:0] wb_addr_d [WB_DEPTH];
  logic [DW-1:0] wb_data_q [WB_DEPTH];
  logic [DW-1:0] wb_data_d [WB_DEPTH];
  logic          ovf_q, ovf_d;
  logic          vld_q   [SRAM_DLY];
  logic          vld_d   [SRAM_DLY];
  logic          fwd_q   [SRAM_DLY];
  logic          fwd_d   [SRAM_DLY];
  logic [DW-1:0] fdata_q [SRAM_DLY];
  logic [DW-1:0] fdata_d [SRAM_DLY];
  logic [BW-1:0] bank_q  [SRAM_DLY];
  logic [BW-1:0] bank_d  [SRAM_DLY];

  logic [BW-1:0] rd_bank, wr_bank, hd_bank;
  logic [RW-1:0] rd_row, wr_row, hd_row;
  logic          wready, accept, drain, direct, push;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data, sram_word;

  assign rd_bank = dpram.raddr[BW-1:0];
  assign rd_row  = dpram.raddr[AW-1:BW];
  assign wr_bank = dpram.waddr[BW-1:0];
  assign wr_row  = dpram.waddr[AW-1:BW];
  assign hd_bank = wb_addr_q[0][BW-1:0];
  assign hd_row  = wb_addr_q[0][AW-1:BW];

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign wready = level_q < 4'(WB_DEPTH);
  assign accept = dpram.wen && wready;
  assign drain  = (level_q != 4'd0) && !(dpram.ren && hd_bank == rd_bank);
  assign direct = accept && (level_q == 4'd0) && !(dpram.ren && wr_bank == rd_bank);
  assign push   = accept && !direct;
  assign tail   = level_q - 4'(drain);

  // Youngest matching entry wins: later (younger) slots override earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (4'(i) < level_q && wb_addr_q[i] == dpram.raddr) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[i];
      end
    end
  end

  always_comb begin
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (drain) begin
      for (int i = 0; i < WB_DEPTH - 1; i++) begin
        wb_addr_d[i] = wb_addr_q[i+1];
        wb_data_d[i] = wb_data_q[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        if (4'(i) == tail) begin
          wb_addr_d[i] = dpram.waddr;
          wb_data_d[i] = dpram.wdata;
        end
      end
    end
    level_d = level_q + 4'(push) - 4'(drain);
    ovf_d   = ovf_q | (dpram.wen & ~wready);
  end

  always_comb begin
    vld_d[0]   = dpram.ren;
    fwd_d[0]   = dpram.ren & fwd_hit;
    fdata_d[0] = fwd_data;
    bank_d[0]  = rd_bank;
    for (int i = 1; i < SRAM_DLY; i++) begin
      vld_d[i]   = vld_q[i-1];
      fwd_d[i]   = fwd_q[i-1];
      fdata_d[i] = fdata_q[i-1];
      bank_d[i]  = bank_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 4'd0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
      for (int i = 0; i < SRAM_DLY; i++) begin
        vld_q[i]   <= 1'b0;
        fwd_q[i]   <= 1'b0;
        fdata_q[i] <= '0;
        bank_q[i]  <= '0;
      end
    end else begin
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      vld_q     <= vld_d;
      fwd_q     <= fwd_d;
      fdata_q   <= fdata_d;
      bank_q    <= bank_d;
    end
  end

  always_comb begin
    sram_word = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_q[SRAM_DLY-1] == BW'(b)) sram_word = spram_rdata[b*DW +: DW];
    end
  end

  assign dpram.wready = wready;
  assign dpram.rvalid = vld_q[SRAM_DLY-1];
  assign dpram.rdata  = !vld_q[SRAM_DLY-1] ? '0 :
                        fwd_q[SRAM_DLY-1]  ? fdata_q[SRAM_DLY-1] : sram_word;
  assign wbuf_level   = level_q;
  assign wr_ovf       = ovf_q;

  // Drain and direct write are mutually exclusive (non-empty vs empty buffer).
  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    logic sel_rd, sel_dr, sel_dw;
    assign sel_rd = !rst && dpram.ren && rd_bank == BW'(gi);
    assign sel_dr = !rst && drain && hd_bank == BW'(gi);
    assign sel_dw = !rst && direct && wr_bank == BW'(gi);
    assign spram_ce[gi] = sel_rd | sel_dr | sel_dw;
    assign spram_we[gi] = sel_dr | sel_dw;
    assign spram_addr[gi*RW +: RW] = sel_rd ? rd_row : sel_dr ? hd_row : sel_dw ? wr_row : '0;
    assign spram_wdata[gi*DW +: DW] = sel_dr ? wb_data_q[0] : sel_dw ? dpram.wdata : '0;
  end
endmodule

// File: tb/tb_pdec_dp2sp_nbank.sv
// Directed bench: a 2-bank and a 4-bank instance on behavioural SRAMs, read
// results checked against a logical-memory scoreboard.
module tb_pdec_dp2sp_nbank;
  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  pdec_dp2sp_nbank_if #(.DW(16), .AW(8)) ifa ();
  pdec_dp2sp_nbank_if #(.DW(16), .AW(8)) ifb ();

  logic [3:0]  lvl_a, lvl_b;
  logic        ovf_a, ovf_b;
  logic [1:0]  ce_a, we_a;
  logic [13:0] addr_a;
  logic [31:0] wd_a, rd_a;
  logic [3:0]  ce_b, we_b;
  logic [23:0] addr_b;
  logic [63:0] wd_b, rd_b;

  pdec_dp2sp_nbank #(.DW(16), .AW(8), .BW(1), .SRAM_DLY(2), .WB_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .dpram(ifa), .wbuf_level(lvl_a), .wr_ovf(ovf_a),
    .spram_ce(ce_a), .spram_we(we_a), .spram_addr(addr_a),
    .spram_wdata(wd_a), .spram_rdata(rd_a));

  pdec_dp2sp_nbank #(.DW(16), .AW(8), .BW(2), .SRAM_DLY(2), .WB_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .dpram(ifb), .wbuf_level(lvl_b), .wr_ovf(ovf_b),
    .spram_ce(ce_b), .spram_we(we_b), .spram_addr(addr_b),
    .spram_wdata(wd_b), .spram_rdata(rd_b));

  // Behavioural banks, two-cycle read latency, preloaded with a stale pattern on reset.
  logic [15:0] mem_a [256];
  logic [15:0] p0_a [2];
  logic [15:0] p1_a [2];
  logic [15:0] mem_b [256];
  logic [15:0] p0_b [4];
  logic [15:0] p1_b [4];

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 256; a++) mem_a[a] <= 16'hC000 | 16'(a);
    end else begin
      for (int b = 0; b < 2; b++)
        if (ce_a[b] && we_a[b]) mem_a[{addr_a[b*7 +: 7], 1'(b)}] <= wd_a[b*16 +: 16];
    end
    for (int b = 0; b < 2; b++) begin
      if (ce_a[b] && !we_a[b]) p0_a[b] <= mem_a[{addr_a[b*7 +: 7], 1'(b)}];
      p1_a[b] <= p0_a[b];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 256; a++) mem_b[a] <= 16'hC000 | 16'(a);
    end else begin
      for (int b = 0; b < 4; b++)
        if (ce_b[b] && we_b[b]) mem_b[{addr_b[b*6 +: 6], 2'(b)}] <= wd_b[b*16 +: 16];
    end
    for (int b = 0; b < 4; b++) begin
      if (ce_b[b] && !we_b[b]) p0_b[b] <= mem_b[{addr_b[b*6 +: 6], 2'(b)}];
      p1_b[b] <= p0_b[b];
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int b = 0; b < 2; b++) rd_a[b*16 +: 16] = p1_a[b];
    for (int b = 0; b < 4; b++) rd_b[b*16 +: 16] = p1_b[b];
  end

  logic [15:0] ref_a [256];
  logic [15:0] ref_b [256];
  exp_t qa[$];
  exp_t qb[$];
  int   checks;
  int   errors;
  int   cyc;
  logic mon_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_a();
    exp_t e;
    if (!mon_en) return;
    if (ifa.rvalid === 1'b1) begin
      if (qa.size() == 0) chk("a_spurious_rvalid", 64'(ifa.rvalid), 64'(0));
      else begin
        e = qa.pop_front();
        chk("a_rdata", 64'(ifa.rdata), 64'(e.data));
        chk("a_rlatency", 64'(cyc), 64'(e.due));
      end
    end else begin
      chk("a_rdata_idle", 64'(ifa.rdata), 64'(0));
      if (qa.size() != 0 && qa[0].due <= cyc) begin
        chk("a_rvalid_missing", 64'(ifa.rvalid), 64'(1));
        void'(qa.pop_front());
      end
    end
  endtask

  task automatic mon_b();
    exp_t e;
    if (!mon_en) return;
    if (ifb.rvalid === 1'b1) begin
      if (qb.size() == 0) chk("b_spurious_rvalid", 64'(ifb.rvalid), 64'(0));
      else begin
        e = qb.pop_front();
        chk("b_rdata", 64'(ifb.rdata), 64'(e.data));
        chk("b_rlatency", 64'(cyc), 64'(e.due));
      end
    end else begin
      chk("b_rdata_idle", 64'(ifb.rdata), 64'(0));
      if (qb.size() != 0 && qb[0].due <= cyc) begin
        chk("b_rvalid_missing", 64'(ifb.rvalid), 64'(1));
        void'(qb.pop_front());
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    mon_a();
    mon_b();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    half();
    adv();
  endtask

  task automatic idle();
    ifa.ren = 1'b0; ifa.raddr = '0; ifa.wen = 1'b0; ifa.waddr = '0; ifa.wdata = '0;
    ifb.ren = 1'b0; ifb.raddr = '0; ifb.wen = 1'b0; ifb.waddr = '0; ifb.wdata = '0;
  endtask

  // Expected read data is taken before the same-cycle write lands (read-before-write).
  task automatic drv_a(input logic ren, input logic [7:0] ra, input logic wen,
                       input logic [7:0] wa, input logic [15:0] wd, input logic rdy);
    exp_t e;
    ifa.ren = ren; ifa.raddr = ra; ifa.wen = wen; ifa.waddr = wa; ifa.wdata = wd;
    chk("a_wready", 64'(ifa.wready), 64'(rdy));
    if (ren) begin
      e.data = ref_a[ra];
      e.due  = cyc + 2;
      qa.push_back(e);
    end
    if (wen && rdy) ref_a[wa] = wd;
  endtask

  task automatic drv_b(input logic ren, input logic [7:0] ra, input logic wen,
                       input logic [7:0] wa, input logic [15:0] wd, input logic rdy);
    exp_t e;
    ifb.ren = ren; ifb.raddr = ra; ifb.wen = wen; ifb.waddr = wa; ifb.wdata = wd;
    chk("b_wready", 64'(ifb.wready), 64'(rdy));
    if (ren) begin
      e.data = ref_b[ra];
      e.due  = cyc + 2;
      qb.push_back(e);
    end
    if (wen && rdy) ref_b[wa] = wd;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ifa.ren = 1'($urandom); ifa.raddr = 8'($urandom); ifa.wen = 1'($urandom);
      ifa.waddr = 8'($urandom); ifa.wdata = 16'($urandom);
      ifb.ren = 1'($urandom); ifb.raddr = 8'($urandom); ifb.wen = 1'($urandom);
      ifb.waddr = 8'($urandom); ifb.wdata = 16'($urandom);
      half();
      chk("rst_ce_a", 64'(ce_a), 64'(0));
      chk("rst_we_a", 64'(we_a), 64'(0));
      chk("rst_ce_b", 64'(ce_b), 64'(0));
      chk("rst_we_b", 64'(we_b), 64'(0));
      adv();
    end
    rst = 1'b0;
    idle();
    qa.delete();
    qb.delete();
    for (int a = 0; a < 256; a++) begin
      ref_a[a] = 16'hC000 | 16'(a);
      ref_b[a] = 16'hC000 | 16'(a);
    end
    half();
    chk("post_rst_wready_a", 64'(ifa.wready), 64'(1));
    chk("post_rst_rvalid_a", 64'(ifa.rvalid), 64'(0));
    chk("post_rst_rdata_a", 64'(ifa.rdata), 64'(0));
    chk("post_rst_level_a", 64'(lvl_a), 64'(0));
    chk("post_rst_ovf_a", 64'(ovf_a), 64'(0));
    chk("post_rst_wready_b", 64'(ifb.wready), 64'(1));
    chk("post_rst_rvalid_b", 64'(ifb.rvalid), 64'(0));
    chk("post_rst_level_b", 64'(lvl_b), 64'(0));
    chk("post_rst_ovf_b", 64'(ovf_b), 64'(0));
    adv();
    mon_en = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    mon_en = 1'b0;
    rst    = 1'b1;
    idle();
    do_reset();

    // Direct write to bank0, then read it back.
    drv_a(1'b0, 8'h00, 1'b1, 8'h04, 16'hA5A5, 1'b1);
    half();
    chk("t2_we", 64'(we_a), 64'(2'b01));
    chk("t2_ce", 64'(ce_a), 64'(2'b01));
    chk("t2_addr0", 64'(addr_a[6:0]), 64'(7'h02));
    chk("t2_wdata0", 64'(wd_a[15:0]), 64'(16'hA5A5));
    chk("t2_idle_addr1", 64'(addr_a[13:7]), 64'(0));
    chk("t2_idle_wdata1", 64'(wd_a[31:16]), 64'(0));
    adv();
    drv_a(1'b1, 8'h04, 1'b0, 8'h00, 16'h0000, 1'b1);
    half();
    chk("t2_rd_ce", 64'(ce_a), 64'(2'b01));
    chk("t2_rd_we", 64'(we_a), 64'(0));
    chk("t2_rd_addr0", 64'(addr_a[6:0]), 64'(7'h02));
    chk("t2_rd_wdata0", 64'(wd_a[15:0]), 64'(0));
    adv();
    idle();
    step(); step(); step();

    // Bank conflict: read wins, write buffered then drained.
    drv_a(1'b1, 8'h06, 1'b1, 8'h08, 16'h1234, 1'b1);
    half();
    chk("t3_ce", 64'(ce_a), 64'(2'b01));
    chk("t3_we", 64'(we_a), 64'(0));
    chk("t3_addr0", 64'(addr_a[6:0]), 64'(7'h03));
    adv();
    idle();
    half();
    chk("t3_level1", 64'(lvl_a), 64'(1));
    chk("t3_drain_we", 64'(we_a), 64'(2'b01));
    chk("t3_drain_addr", 64'(addr_a[6:0]), 64'(7'h04));
    chk("t3_drain_data", 64'(wd_a[15:0]), 64'(16'h1234));
    adv();
    half();
    chk("t3_level0", 64'(lvl_a), 64'(0));
    adv();
    step(); step();

    // Forwarding: the blocked head supplies the read instead of stale SRAM data.
    drv_a(1'b1, 8'h06, 1'b1, 8'h08, 16'h5678, 1'b1);
    step();
    drv_a(1'b1, 8'h08, 1'b0, 8'h00, 16'h0000, 1'b1);
    half();
    chk("t4_level_blocked", 64'(lvl_a), 64'(1));
    chk("t4_we_blocked", 64'(we_a), 64'(0));
    adv();
    idle();
    half();
    chk("t4_drain_we", 64'(we_a), 64'(2'b01));
    chk("t4_drain_data", 64'(wd_a[15:0]), 64'(16'h5678));
    adv();
    half();
    chk("t4_level0", 64'(lvl_a), 64'(0));
    adv();
    step(); step();

    // Overflow: buffer fills under constant bank0 reads, third write is dropped.
    drv_a(1'b1, 8'h00, 1'b1, 8'h02, 16'h1111, 1'b1);
    step();
    drv_a(1'b1, 8'h00, 1'b1, 8'h04, 16'h2222, 1'b1);
    half();
    chk("t5_level1", 64'(lvl_a), 64'(1));
    adv();
    drv_a(1'b1, 8'h00, 1'b1, 8'h06, 16'h3333, 1'b0);
    half();
    chk("t5_level2", 64'(lvl_a), 64'(2));
    chk("t5_ovf_before", 64'(ovf_a), 64'(0));
    adv();
    drv_a(1'b1, 8'h02, 1'b0, 8'h00, 16'h0000, 1'b0);
    half();
    chk("t5_ovf_set", 64'(ovf_a), 64'(1));
    chk("t5_level_full", 64'(lvl_a), 64'(2));
    adv();
    idle();
    half();
    chk("t5_drain1_we", 64'(we_a), 64'(2'b01));
    chk("t5_drain1_addr", 64'(addr_a[6:0]), 64'(7'h01));
    chk("t5_drain1_data", 64'(wd_a[15:0]), 64'(16'h1111));
    adv();
    half();
    chk("t5_level_after1", 64'(lvl_a), 64'(1));
    chk("t5_drain2_addr", 64'(addr_a[6:0]), 64'(7'h02));
    chk("t5_drain2_data", 64'(wd_a[15:0]), 64'(16'h2222));
    adv();
    drv_a(1'b1, 8'h06, 1'b0, 8'h00, 16'h0000, 1'b1);
    half();
    chk("t5_level_empty", 64'(lvl_a), 64'(0));
    chk("t5_ovf_sticky", 64'(ovf_a), 64'(1));
    adv();
    drv_a(1'b1, 8'h04, 1'b0, 8'h00, 16'h0000, 1'b1);
    step();
    idle();
    step(); step(); step();
    chk("t5_ovf_still", 64'(ovf_a), 64'(1));

    // Ordering on four banks: two writes to one address drain in order.
    drv_b(1'b1, 8'h05, 1'b1, 8'h01, 16'h0001, 1'b1);
    half();
    chk("t6_ce", 64'(ce_b), 64'(4'b0010));
    chk("t6_we", 64'(we_b), 64'(0));
    adv();
    drv_b(1'b1, 8'h05, 1'b1, 8'h01, 16'h0002, 1'b1);
    half();
    chk("t6_level1", 64'(lvl_b), 64'(1));
    adv();
    drv_b(1'b1, 8'h01, 1'b0, 8'h00, 16'h0000, 1'b0);
    half();
    chk("t6_level2", 64'(lvl_b), 64'(2));
    chk("t6_we_blocked", 64'(we_b), 64'(0));
    adv();
    idle();
    half();
    chk("t6_drain1_we", 64'(we_b), 64'(4'b0010));
    chk("t6_drain1_addr", 64'(addr_b[11:6]), 64'(0));
    chk("t6_drain1_data", 64'(wd_b[31:16]), 64'(16'h0001));
    adv();
    half();
    chk("t6_drain2_we", 64'(we_b), 64'(4'b0010));
    chk("t6_drain2_data", 64'(wd_b[31:16]), 64'(16'h0002));
    chk("t6_level_after1", 64'(lvl_b), 64'(1));
    adv();
    drv_b(1'b1, 8'h01, 1'b0, 8'h00, 16'h0000, 1'b1);
    half();
    chk("t6_level0", 64'(lvl_b), 64'(0));
    adv();
    idle();
    step(); step(); step();
    chk("a_queue_drained", 64'(qa.size()), 64'(0));
    chk("b_queue_drained", 64'(qb.size()), 64'(0));

    // Reset with a read in flight: it must vanish and the sticky flag must clear.
    drv_a(1'b1, 8'h04, 1'b0, 8'h00, 16'h0000, 1'b1);
    step();
    do_reset();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
